// File: rtl/descriptor_status_updater.sv
// Read-modify-write engine that sets the Used/Modified bits of page descriptors.
// Requests are queued in a small FIFO and serviced one at a time under a bus lock.
module descriptor_status_updater #(
  parameter int         DESCR_WIDTH    = 32,
  parameter int         PA_WIDTH       = 32,
  parameter int         DT_HI          = DESCR_WIDTH-1,
  parameter int         DT_LO          = DESCR_WIDTH-2,
  parameter logic [1:0] DT_PAGE        = 2'd1,
  parameter int         M_BIT          = DESCR_WIDTH-7,
  parameter int         U_BIT          = DESCR_WIDTH-8,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   upd_valid_i,
  output logic                   upd_ready_o,
  input  logic [PA_WIDTH-1:0]    upd_addr_i,
  input  logic                   upd_set_u_i,
  input  logic                   upd_set_m_i,
  output logic                   done_o,
  output logic [PA_WIDTH-1:0]    done_addr_o,
  output logic [1:0]             done_status_o,
  output logic                   done_wrote_o,
  output logic                   busy_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic                   mem_lock_o,
  output logic [PA_WIDTH-1:0]    mem_addr_o,
  output logic [DESCR_WIDTH-1:0] mem_wdata_o,
  input  logic [DESCR_WIDTH-1:0] mem_rdata_i,
  input  logic                   mem_ack_i,
  input  logic                   mem_err_i
);

  localparam int ENTRY_W = PA_WIDTH + 2;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CHECK, ST_WR, ST_RESP} state_t;

  state_t                  state_reg;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [TO_W-1:0]         to_cnt_reg;
  logic [PA_WIDTH-1:0]     work_addr_reg;
  logic                    work_set_u_reg, work_set_m_reg;
  logic [DESCR_WIDTH-1:0]  rdata_reg;
  logic [DESCR_WIDTH-1:0]  set_mask;
  logic [ENTRY_W-1:0]      fifo_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]      head_entry;
  logic                    push, pop, fifo_empty, need;
  logic                    fin;
  logic [1:0]              fin_status;
  logic                    fin_wrote;

  assign fifo_empty = (count_reg == '0);
  assign push       = upd_valid_i && upd_ready_o;
  assign pop        = (state_reg == ST_IDLE) && !fifo_empty;
  assign head_entry = fifo_q[rd_ptr_reg];

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    logic [ENTRY_W-1:0] slot_reg;
    always_ff @(posedge clk_i) begin
      if (push && wr_ptr_reg == PTR_W'(gi))
        slot_reg <= {upd_addr_i, upd_set_u_i, upd_set_m_i};
    end
    assign fifo_q[gi] = slot_reg;
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (!push && pop)
      count_next = count_reg - 1'b1;
  end

  // Ready and busy are registered, so they are computed from next-cycle values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      upd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg   <= count_next;
      upd_ready_o <= (count_next != CNT_W'(FIFO_DEPTH));
      busy_o      <= ((state_reg == ST_IDLE) ? !fifo_empty : (state_reg != ST_RESP))
                     || (count_next != '0);
    end
  end

  always_comb begin
    set_mask        = '0;
    set_mask[U_BIT] = work_set_u_reg;
    set_mask[M_BIT] = work_set_m_reg;
  end
  assign need = |(set_mask & ~rdata_reg);

  // Every path into RESP is decided here; err always wins over ack.
  always_comb begin
    fin        = 1'b0;
    fin_status = 2'd0;
    fin_wrote  = 1'b0;
    case (state_reg)
      ST_RD: begin
        if (mem_err_i) begin
          fin = 1'b1; fin_status = 2'd1;
        end else if (!mem_ack_i && to_cnt_reg == TO_LAST) begin
          fin = 1'b1; fin_status = 2'd3;
        end
      end
      ST_CHECK: begin
        if (rdata_reg[DT_HI:DT_LO] != DT_PAGE) begin
          fin = 1'b1; fin_status = 2'd2;
        end else if (!need) begin
          fin = 1'b1; fin_status = 2'd0;
        end
      end
      ST_WR: begin
        fin_wrote = 1'b1;
        if (mem_err_i) begin
          fin = 1'b1; fin_status = 2'd1;
        end else if (mem_ack_i) begin
          fin = 1'b1; fin_status = 2'd0;
        end else if (to_cnt_reg == TO_LAST) begin
          fin = 1'b1; fin_status = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      to_cnt_reg     <= '0;
      work_addr_reg  <= '0;
      work_set_u_reg <= 1'b0;
      work_set_m_reg <= 1'b0;
      rdata_reg      <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_lock_o     <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      done_o         <= 1'b0;
      done_addr_o    <= '0;
      done_status_o  <= 2'd0;
      done_wrote_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            work_addr_reg  <= head_entry[ENTRY_W-1:2];
            work_set_u_reg <= head_entry[1];
            work_set_m_reg <= head_entry[0];
            mem_addr_o     <= head_entry[ENTRY_W-1:2];
            mem_req_o      <= 1'b1;
            mem_we_o       <= 1'b0;
            mem_lock_o     <= 1'b1;
            to_cnt_reg     <= '0;
            state_reg      <= ST_RD;
          end
        end
        ST_RD: begin
          if (mem_ack_i) begin
            rdata_reg <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state_reg <= ST_CHECK;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_CHECK: begin
          mem_wdata_o <= rdata_reg | set_mask;
          mem_we_o    <= 1'b1;
          mem_req_o   <= 1'b1;
          to_cnt_reg  <= '0;
          state_reg   <= ST_WR;
        end
        ST_WR: begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
      // Completion overrides whatever the state branch scheduled above.
      if (fin) begin
        state_reg     <= ST_RESP;
        mem_req_o     <= 1'b0;
        mem_we_o      <= 1'b0;
        mem_lock_o    <= 1'b0;
        done_o        <= 1'b1;
        done_addr_o   <= work_addr_reg;
        done_status_o <= fin_status;
        done_wrote_o  <= fin_wrote;
      end
    end
  end

endmodule

// File: tb/tb_descriptor_status_updater.sv
// Directed test of descriptor_status_updater with cycle-exact expectations.
// Bus responses are driven by hand from the single stimulus sequence.
module tb_descriptor_status_updater;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_addr = '0;
  logic        upd_set_u = 1'b0;
  logic        upd_set_m = 1'b0;
  logic        done;
  logic [31:0] done_addr;
  logic [1:0]  done_status;
  logic        done_wrote;
  logic        busy;
  logic        mem_req, mem_we, mem_lock;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;

  int total = 0;
  int bad   = 0;

  descriptor_status_updater #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_addr_i(upd_addr),
    .upd_set_u_i(upd_set_u), .upd_set_m_i(upd_set_m),
    .done_o(done), .done_addr_o(done_addr), .done_status_o(done_status),
    .done_wrote_o(done_wrote), .busy_o(busy),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_lock_o(mem_lock),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .mem_err_i(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [31:0] a, input logic su, input logic sm);
    upd_valid = 1'b1; upd_addr = a; upd_set_u = su; upd_set_m = sm;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic show_done();
    $display("txn addr=%h status=%0d wrote=%0d t=%0t", done_addr, done_status, done_wrote, $time);
  endtask

  // Services one no-write request in FIFO order with bounded waits.
  task automatic serve_nowrite(input logic [31:0] a);
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
    chk("fifo_req_seen", mem_req, 1);
    chk("fifo_rd_addr", mem_addr, a);
    mem_ack = 1'b1; mem_rdata = 32'h4300_0000;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 10 && done !== 1'b1; i++) tick();
    chk("fifo_done_seen", done, 1);
    chk("fifo_done_addr", done_addr, a);
    chk("fifo_done_status", done_status, 0);
    show_done();
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_lock", mem_lock, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", upd_ready, 1);

    // 1: set U on a page descriptor -> locked write 0x41000000, done at T+5
    push1(32'h1000, 1'b1, 1'b0);                 // now T+1
    chk("t1_busy", busy, 1);
    chk("t1_req_t1", mem_req, 0);
    tick();                                       // T+2
    chk("t1_rd_req", mem_req, 1);
    chk("t1_rd_we", mem_we, 0);
    chk("t1_rd_lock", mem_lock, 1);
    chk("t1_rd_addr", mem_addr, 32'h1000);
    mem_ack = 1'b1; mem_rdata = 32'h4000_0000;
    tick();                                       // T+3 CHECK
    mem_ack = 1'b0;
    chk("t1_chk_req", mem_req, 0);
    chk("t1_chk_lock", mem_lock, 1);
    tick();                                       // T+4 WR
    chk("t1_wr_req", mem_req, 1);
    chk("t1_wr_we", mem_we, 1);
    chk("t1_wr_lock", mem_lock, 1);
    chk("t1_wr_data", mem_wdata, 32'h4100_0000);
    chk("t1_wr_addr", mem_addr, 32'h1000);
    chk("t1_done_early", done, 0);
    mem_ack = 1'b1;
    tick();                                       // T+5 RESP
    mem_ack = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_status", done_status, 0);
    chk("t1_wrote", done_wrote, 1);
    chk("t1_done_addr", done_addr, 32'h1000);
    chk("t1_resp_lock", mem_lock, 0);
    show_done();
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: U and M already set -> no write, done at T+4
    push1(32'h2000, 1'b1, 1'b1);
    tick();
    chk("t2_rd_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h4300_0000;
    tick();
    mem_ack = 1'b0;
    chk("t2_chk_lock", mem_lock, 1);
    tick();                                       // T+4
    chk("t2_done", done, 1);
    chk("t2_status", done_status, 0);
    chk("t2_wrote", done_wrote, 0);
    chk("t2_req", mem_req, 0);
    chk("t2_lock", mem_lock, 0);
    chk("t2_done_addr", done_addr, 32'h2000);
    show_done();
    tick();

    // 3: invalid DT -> status 2, never a write
    push1(32'h3000, 1'b1, 1'b0);
    tick();
    chk("t3_rd_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0000;
    tick();
    mem_ack = 1'b0;
    chk("t3_chk_req", mem_req, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_status", done_status, 2);
    chk("t3_wrote", done_wrote, 0);
    chk("t3_we", mem_we, 0);
    show_done();
    tick();

    // 4: read never acked -> req high T+2..T+5, timeout done at T+6
    push1(32'h4000, 1'b1, 1'b0);
    tick(); tick(); tick();                       // T+4
    chk("t4_req_held", mem_req, 1);
    tick();                                       // T+5
    chk("t4_req_last", mem_req, 1);
    chk("t4_not_done", done, 0);
    tick();                                       // T+6
    chk("t4_req_drop", mem_req, 0);
    chk("t4_done", done, 1);
    chk("t4_status", done_status, 3);
    chk("t4_wrote", done_wrote, 0);
    show_done();
    tick();

    // 5: error on write -> status 1, wrote 1
    push1(32'h5000, 1'b0, 1'b1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h4000_0000;
    tick();
    mem_ack = 1'b0;
    tick();                                       // T+4 WR
    chk("t5_wr_data", mem_wdata, 32'h4200_0000);
    mem_err = 1'b1;
    tick();
    mem_err = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_status", done_status, 1);
    chk("t5_wrote", done_wrote, 1);
    show_done();
    tick();

    // 6: stalled read on A while B..E fill the FIFO; F is refused
    upd_valid = 1'b1; upd_addr = 32'h6000; upd_set_u = 1'b1; upd_set_m = 1'b0;
    tick();                                       // T0+1
    upd_addr = 32'h6100;
    tick();                                       // T0+2
    chk("t6_a_rd", mem_addr, 32'h6000);
    upd_addr = 32'h6200;
    tick();
    upd_addr = 32'h6300;
    tick();                                       // T0+4
    chk("t6_ready_before", upd_ready, 1);
    upd_addr = 32'h6400;
    tick();                                       // T0+5
    chk("t6_ready_full", upd_ready, 0);
    upd_addr = 32'h6500;
    tick();                                       // T0+6
    upd_valid = 1'b0;
    chk("t6_a_done", done, 1);
    chk("t6_a_status", done_status, 3);
    chk("t6_a_addr", done_addr, 32'h6000);
    show_done();
    serve_nowrite(32'h6100);
    serve_nowrite(32'h6200);
    serve_nowrite(32'h6300);
    serve_nowrite(32'h6400);
    tick();
    chk("t6_drained", busy, 0);

    // 7: reset asserted mid-write with another request queued
    push1(32'h7000, 1'b1, 1'b0);                  // T+1
    upd_valid = 1'b1; upd_addr = 32'h7100;
    tick();                                       // T+2
    upd_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h4000_0000;
    tick();
    mem_ack = 1'b0;
    tick();                                       // T+4 WR
    chk("t7_in_wr", mem_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_req", mem_req, 0);
    chk("t7_lock", mem_lock, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7_quiet_done", done, 0);
      chk("t7_quiet_req", mem_req, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
